y86_regfile_port_ctrl: RTL and testbench
========================================

// Module: y86_regfile_port_ctrl
// PURPOSE
//  Initiator side of the Y86-64 register-file interface. Decodes each instruction
//  (icode/ifun/rA/rB) into read addresses srcA/srcB and write tags dstE/dstM.
//  Tracks outstanding writes in a scoreboard and stalls RAW/WAW hazards.
//  Turns returning writeback results into register-file write strobes.
//  Sits between fetch (valid/ready in), execute (valid/ready out) and the register file.
// PARAMETERS
//  MAX_INFLIGHT  4   max issued-but-not-written-back instructions (1..15)
//  W             64  data width of valE/valM
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  in_valid     in   1   fetch offers an instruction
//  in_ready     out  1   instruction accepted when in_valid & in_ready
//  in_icode     in   4   instruction code 0x0..0xB (others are invalid)
//  in_ifun      in   4   function code (icode 2: 0 = rrmovq, else cmovXX)
//  in_ra, in_rb in   4   register specifiers (0xF = none)
//  rf_src_a     out  4   register-file read address A (combinational from in_*)
//  rf_src_b     out  4   register-file read address B (combinational from in_*)
//  ex_valid     out  1   issued instruction presented to execute (registered)
//  ex_ready     in   1   execute accepts
//  ex_icode     out  4   registered icode
//  ex_dst_e     out  4   registered destination for valE
//  ex_dst_m     out  4   registered destination for valM
//  ex_cmov      out  1   instruction is a conditional move
//  ex_invalid   out  1   icode > 0xB
//  wb_valid     in   1   one completed instruction returns (always accepted)
//  wb_dst_e     in   4   returned dstE tag
//  wb_dst_m     in   4   returned dstM tag
//  wb_val_e     in   W   returned valE
//  wb_val_m     in   W   returned valM
//  wb_cnd       in   1   condition result
//  wb_cmov      in   1   returned instruction is a cmov
//  rf_we_e      out  1   write strobe, port E
//  rf_dst_e     out  4   write address, port E
//  rf_val_e     out  W   write data, port E
//  rf_we_m      out  1   write strobe, port M
//  rf_dst_m     out  4   write address, port M
//  rf_val_m     out  W   write data, port M
//  halted       out  1   halt accepted and in-flight count is 0
// BEHAVIOUR
//  Reset:
//   - ex_valid=0, ex_* tags=0xF, ex_icode/ex_cmov/ex_invalid=0.
//   - pending[14:0]=0, inflight=0, halt_seen=0, halted=0.
//   - Reset mid-operation discards all in-flight state.
//  Decode (src A/B, dst E/M):
//   - 0/1/7, invalid:  F/F, F/F
//   - 2:  rA/F,  rB/F
//   - 3:  F/F,   rB/F
//   - 4:  rA/rB, F/F
//   - 5:  F/rB,  F/rA
//   - 6:  rA/rB, rB/F
//   - 8:  F/4,   4/F
//   - 9:  4/4,   4/F
//   - A:  rA/4,  4/F
//   - B:  4/4,   4/rA
//  Hazards:
//   - hazard = any non-F src or dst whose pending bit is set.
//   - in_ready = !halt_seen & !hazard & (inflight < MAX_INFLIGHT) & (!ex_valid | ex_ready).
//  Issue:
//   - On accept, the ex_* registers load next cycle (1-cycle latency).
//   - pending[dstE] and pending[dstM] are set and inflight increments.
//   - dstE==dstM (popq %rsp) sets a single bit.
//  Writeback (same cycle, combinational):
//   - rf_we_m = wb_valid & wb_dst_m!=F.
//   - rf_we_e = wb_valid & wb_dst_e!=F & !(wb_cmov & !wb_cnd) & wb_dst_e!=wb_dst_m.
//   - When dstE==dstM, M wins.
//   - At the edge: clear pending for both tags (the cmov tag is cleared even when the
//     write is suppressed) and decrement inflight.
//  Scoreboard timing:
//   - The check uses registered bits, so a register cleared by writeback is still
//     busy in that cycle and the dependent instruction issues one cycle later.
//   - Simultaneous issue and writeback: set and clear apply to distinct registers
//     (guaranteed by WAW stall); inflight changes by net 0.
//  Halt (icode 0):
//   - Accepted normally, then halt_seen=1 and in_ready stays 0 until reset.
//   - halted=1 when halt_seen & inflight==0.
//  Assertions:
//   - wb_valid with inflight==0 is illegal.
//   - A wb tag whose pending bit is clear is illegal.
//   - ex_* is held stable while ex_valid & !ex_ready.
// STRUCTURE
//  - Package y86_pkg: icode localparams (IHALT..IPOPQ), RNONE=4'hF, RRSP=4'h4.
//  - Sub-module y86_scoreboard: pending bits, set/clear ports, 4 lookup ports, inflight counter.
//  - The decode table is a combinational function in this module.
// TESTING
//  1. Reset; irmovq rB=2, then addq rA=2,rB=3 -> addq stalls until wb dst_e=2;
//     pending[2] clears; addq issues the next cycle.
//  2. pushq rA=1 -> rf_src_a=1, rf_src_b=4, ex_dst_e=4; popq behind it stalls on RSP
//     until pushq writes back.
//  3. popq rA=4 -> single pending bit 4; wb val_e=0x100, val_m=0x55 -> only
//     rf_we_m=1, rf_dst_m=4, rf_val_m=0x55.
//  4. cmovle rA=1,rB=5 with wb_cnd=0 -> rf_we_e=0; pending[5] still clears; next
//     user of r5 issues.
//  5. Issue 4 independent irmovq with ex_ready=1 and no wb -> in_ready=0 at
//     inflight=4; one wb -> in_ready=1.
//  6. halt with 2 in flight -> in_ready=0; halted=1 after the second wb; assert
//     reset mid-stream -> all pending=0, ex_valid=0.

Source files
------------

// File: rtl/y86_regfile_port_ctrl_pkg.sv
// Y86-64 register-file port controller: shared icodes, register ids
// and the decoded-instruction bundle.
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RRSP  = 4'h4;

  typedef struct packed {
    logic [3:0] src_a;
    logic [3:0] src_b;
    logic [3:0] dst_e;
    logic [3:0] dst_m;
    logic       cmov;
    logic       invalid;
  } dec_t;

endpackage

// File: rtl/y86_regfile_port_ctrl_scoreboard.sv
// Y86-64 write scoreboard: one pending bit per register plus
// a count of issued instructions not yet written back.
module y86_scoreboard
  import y86_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       set_valid,
  input  logic [3:0] set_e,
  input  logic [3:0] set_m,
  input  logic       clr_valid,
  input  logic [3:0] clr_e,
  input  logic [3:0] clr_m,
  input  logic [3:0] q_a,
  input  logic [3:0] q_b,
  input  logic [3:0] q_c,
  input  logic [3:0] q_d,
  output logic       busy_a,
  output logic       busy_b,
  output logic       busy_c,
  output logic       busy_d,
  output logic [3:0] inflight
);

  logic [14:0] pending;
  logic [15:0] pend16;
  logic [15:0] set_mask;
  logic [15:0] clr_mask;

  function automatic logic [15:0] onehot(input logic [3:0] r);
    return 16'(1) << r;
  endfunction

  // Slot 15 is RNONE and is never busy.
  assign pend16 = {1'b0, pending};

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_valid) set_mask = onehot(set_e) | onehot(set_m);
    if (clr_valid) clr_mask = onehot(clr_e) | onehot(clr_m);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending  <= '0;
      inflight <= '0;
    end else begin
      pending  <= (pending & ~clr_mask[14:0]) | set_mask[14:0];
      inflight <= inflight + 4'(set_valid) - 4'(clr_valid);
    end
  end

  assign busy_a = pend16[q_a];
  assign busy_b = pend16[q_b];
  assign busy_c = pend16[q_c];
  assign busy_d = pend16[q_d];

  a_wb_inflight: assert property (
    @(posedge clk) disable iff (reset)
    clr_valid |-> inflight != 4'd0);

  a_wb_pending: assert property (
    @(posedge clk) disable iff (reset)
    clr_valid |-> (clr_e == RNONE || pend16[clr_e])
               && (clr_m == RNONE || pend16[clr_m]));

endmodule

// File: rtl/y86_regfile_port_ctrl.sv
// Y86-64 register-file port controller: decode, hazard stall,
// issue to execute and writeback strobe generation.
module y86_regfile_port_ctrl
  import y86_pkg::*;
#(
  parameter int MAX_INFLIGHT = 4,
  parameter int W            = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [3:0]   in_icode,
  input  logic [3:0]   in_ifun,
  input  logic [3:0]   in_ra,
  input  logic [3:0]   in_rb,
  output logic [3:0]   rf_src_a,
  output logic [3:0]   rf_src_b,
  output logic         ex_valid,
  input  logic         ex_ready,
  output logic [3:0]   ex_icode,
  output logic [3:0]   ex_dst_e,
  output logic [3:0]   ex_dst_m,
  output logic         ex_cmov,
  output logic         ex_invalid,
  input  logic         wb_valid,
  input  logic [3:0]   wb_dst_e,
  input  logic [3:0]   wb_dst_m,
  input  logic [W-1:0] wb_val_e,
  input  logic [W-1:0] wb_val_m,
  input  logic         wb_cnd,
  input  logic         wb_cmov,
  output logic         rf_we_e,
  output logic [3:0]   rf_dst_e,
  output logic [W-1:0] rf_val_e,
  output logic         rf_we_m,
  output logic [3:0]   rf_dst_m,
  output logic [W-1:0] rf_val_m,
  output logic         halted
);

  function automatic dec_t decode(
    input logic [3:0] icode,
    input logic [3:0] ifun,
    input logic [3:0] ra,
    input logic [3:0] rb
  );
    dec_t d;
    d = '{src_a: RNONE, src_b: RNONE,
          dst_e: RNONE, dst_m: RNONE,
          cmov: 1'b0, invalid: 1'b0};
    unique case (1'b1)
      icode == IRRMOVQ: begin
        d.src_a = ra;
        d.dst_e = rb;
        d.cmov  = ifun != 4'h0;
      end
      icode == IIRMOVQ: d.dst_e = rb;
      icode == IRMMOVQ: begin
        d.src_a = ra;
        d.src_b = rb;
      end
      icode == IMRMOVQ: begin
        d.src_b = rb;
        d.dst_m = ra;
      end
      icode == IOPQ: begin
        d.src_a = ra;
        d.src_b = rb;
        d.dst_e = rb;
      end
      icode == ICALL: begin
        d.src_b = RRSP;
        d.dst_e = RRSP;
      end
      icode == IRET: begin
        d.src_a = RRSP;
        d.src_b = RRSP;
        d.dst_e = RRSP;
      end
      icode == IPUSHQ: begin
        d.src_a = ra;
        d.src_b = RRSP;
        d.dst_e = RRSP;
      end
      icode == IPOPQ: begin
        d.src_a = RRSP;
        d.src_b = RRSP;
        d.dst_e = RRSP;
        d.dst_m = ra;
      end
      icode > IPOPQ: d.invalid = 1'b1;
      default: ;
    endcase
    return d;
  endfunction

  dec_t       dec;
  logic       busy_a, busy_b, busy_c, busy_d;
  logic       hazard;
  logic       accept;
  logic       halt_seen;
  logic [3:0] inflight;

  assign dec      = decode(in_icode, in_ifun, in_ra, in_rb);
  assign rf_src_a = dec.src_a;
  assign rf_src_b = dec.src_b;

  y86_scoreboard u_sb (
    .clk       (clk),
    .reset     (reset),
    .set_valid (accept),
    .set_e     (dec.dst_e),
    .set_m     (dec.dst_m),
    .clr_valid (wb_valid),
    .clr_e     (wb_dst_e),
    .clr_m     (wb_dst_m),
    .q_a       (dec.src_a),
    .q_b       (dec.src_b),
    .q_c       (dec.dst_e),
    .q_d       (dec.dst_m),
    .busy_a    (busy_a),
    .busy_b    (busy_b),
    .busy_c    (busy_c),
    .busy_d    (busy_d),
    .inflight  (inflight)
  );

  assign hazard   = busy_a | busy_b | busy_c | busy_d;
  assign in_ready = !halt_seen && !hazard
                 && (inflight < 4'(MAX_INFLIGHT))
                 && (!ex_valid || ex_ready);
  assign accept   = in_valid && in_ready;
  assign halted   = halt_seen && inflight == 4'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid   <= 1'b0;
      ex_icode   <= 4'h0;
      ex_dst_e   <= RNONE;
      ex_dst_m   <= RNONE;
      ex_cmov    <= 1'b0;
      ex_invalid <= 1'b0;
      halt_seen  <= 1'b0;
    end else begin
      if (accept) begin
        ex_valid   <= 1'b1;
        ex_icode   <= in_icode;
        ex_dst_e   <= dec.dst_e;
        ex_dst_m   <= dec.dst_m;
        ex_cmov    <= dec.cmov;
        ex_invalid <= dec.invalid;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
      if (accept && in_icode == IHALT) halt_seen <= 1'b1;
    end
  end

  // popq %rsp returns the same tag on both ports; the loaded value wins.
  assign rf_we_m  = wb_valid && wb_dst_m != RNONE;
  assign rf_we_e  = wb_valid && wb_dst_e != RNONE
                 && !(wb_cmov && !wb_cnd)
                 && wb_dst_e != wb_dst_m;
  assign rf_dst_e = wb_dst_e;
  assign rf_val_e = wb_val_e;
  assign rf_dst_m = wb_dst_m;
  assign rf_val_m = wb_val_m;

  a_ex_stable: assert property (
    @(posedge clk) disable iff (reset)
    ex_valid && !ex_ready |=> ex_valid
      && $stable({ex_icode, ex_dst_e, ex_dst_m, ex_cmov, ex_invalid}));

endmodule

// File: tb/tb_y86_regfile_port_ctrl.sv
// Bench for y86_regfile_port_ctrl: decode table vectors, an issue
// scoreboard queue and hand sequences for stalls, halt and reset.
module tb_y86_regfile_port_ctrl;

  localparam int W = 64;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   in_icode, in_ifun, in_ra, in_rb;
  logic [3:0]   rf_src_a, rf_src_b;
  logic         ex_valid, ex_ready;
  logic [3:0]   ex_icode, ex_dst_e, ex_dst_m;
  logic         ex_cmov, ex_invalid;
  logic         wb_valid;
  logic [3:0]   wb_dst_e, wb_dst_m;
  logic [W-1:0] wb_val_e, wb_val_m;
  logic         wb_cnd, wb_cmov;
  logic         rf_we_e, rf_we_m;
  logic [3:0]   rf_dst_e, rf_dst_m;
  logic [W-1:0] rf_val_e, rf_val_m;
  logic         halted;

  y86_regfile_port_ctrl #(.MAX_INFLIGHT(4), .W(W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_icode(in_icode), .in_ifun(in_ifun),
    .in_ra(in_ra), .in_rb(in_rb),
    .rf_src_a(rf_src_a), .rf_src_b(rf_src_b),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_icode(ex_icode), .ex_dst_e(ex_dst_e),
    .ex_dst_m(ex_dst_m), .ex_cmov(ex_cmov),
    .ex_invalid(ex_invalid),
    .wb_valid(wb_valid), .wb_dst_e(wb_dst_e),
    .wb_dst_m(wb_dst_m), .wb_val_e(wb_val_e),
    .wb_val_m(wb_val_m), .wb_cnd(wb_cnd),
    .wb_cmov(wb_cmov),
    .rf_we_e(rf_we_e), .rf_dst_e(rf_dst_e),
    .rf_val_e(rf_val_e), .rf_we_m(rf_we_m),
    .rf_dst_m(rf_dst_m), .rf_val_m(rf_val_m),
    .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] icode, ifun, ra, rb;
    logic [3:0] sa, sb, de, dm;
    logic       cm, inv, we_e, we_m;
  } vec_t;

  typedef struct {
    logic [3:0] icode, de, dm;
    logic       cm, inv;
  } exp_t;

  exp_t q[$];
  exp_t exp_cur;
  vec_t tbl[13];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t v(
    input logic [3:0] icode, ifun, ra, rb, sa, sb, de, dm,
    input logic cm, inv, we_e, we_m);
    vec_t r;
    r.icode = icode; r.ifun = ifun; r.ra = ra; r.rb = rb;
    r.sa = sa; r.sb = sb; r.de = de; r.dm = dm;
    r.cm = cm; r.inv = inv; r.we_e = we_e; r.we_m = we_m;
    return r;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (ex_valid && ex_ready) begin
      if (q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL ex_unexpected: got icode %0h expected none",
                 ex_icode);
      end else begin
        e = q.pop_front();
        chk("ex_icode", ex_icode, e.icode);
        chk("ex_dst_e", ex_dst_e, e.de);
        chk("ex_dst_m", ex_dst_m, e.dm);
        chk("ex_cmov", ex_cmov, e.cm);
        chk("ex_invalid", ex_invalid, e.inv);
      end
    end
    if (in_valid && in_ready) q.push_back(exp_cur);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input vec_t t);
    in_icode = t.icode;
    in_ifun  = t.ifun;
    in_ra    = t.ra;
    in_rb    = t.rb;
    exp_cur  = '{t.icode, t.de, t.dm, t.cm, t.inv};
    in_valid = 1'b1;
  endtask

  task automatic issue(input vec_t t, input string name);
    bit got;
    got = 1'b0;
    set_in(t);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL %s: got no accept expected accept", name);
      in_valid = 1'b0;
    end
    tick;
    in_valid = 1'b0;
  endtask

  task automatic wb_drive(input logic [3:0] de, dm,
                          input logic [63:0] ve, vm,
                          input logic cnd, cm);
    wb_valid = 1'b1;
    wb_dst_e = de;
    wb_dst_m = dm;
    wb_val_e = ve;
    wb_val_m = vm;
    wb_cnd   = cnd;
    wb_cmov  = cm;
  endtask

  task automatic wb(input logic [3:0] de, dm,
                    input logic [63:0] ve, vm,
                    input logic cnd, cm, xe, xm,
                    input string name);
    wb_drive(de, dm, ve, vm, cnd, cm);
    @(negedge clk);
    chk({name, "_we_e"}, rf_we_e, xe);
    chk({name, "_we_m"}, rf_we_m, xm);
    if (xe) begin
      chk({name, "_dst_e"}, rf_dst_e, de);
      chk({name, "_val_e"}, rf_val_e, ve);
    end
    if (xm) begin
      chk({name, "_dst_m"}, rf_dst_m, dm);
      chk({name, "_val_m"}, rf_val_m, vm);
    end
    tick;
    wb_valid = 1'b0;
  endtask

  task automatic do_reset;
    reset    = 1'b1;
    in_valid = 1'b0;
    wb_valid = 1'b0;
    ex_ready = 1'b1;
    in_icode = 4'h0;
    in_ifun  = 4'h0;
    in_ra    = 4'hF;
    in_rb    = 4'hF;
    q.delete();
    repeat (2) tick;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    wb_dst_e = 4'hF; wb_dst_m = 4'hF;
    wb_val_e = '0;   wb_val_m = '0;
    wb_cnd   = 1'b0; wb_cmov  = 1'b0;
    tbl[0]  = v(4'h1,4'h0,4'h1,4'h3, 4'hF,4'hF,4'hF,4'hF, 0,0,0,0);
    tbl[1]  = v(4'h2,4'h0,4'h1,4'h3, 4'h1,4'hF,4'h3,4'hF, 0,0,1,0);
    tbl[2]  = v(4'h2,4'h3,4'h1,4'h3, 4'h1,4'hF,4'h3,4'hF, 1,0,1,0);
    tbl[3]  = v(4'h3,4'h0,4'hF,4'h3, 4'hF,4'hF,4'h3,4'hF, 0,0,1,0);
    tbl[4]  = v(4'h4,4'h0,4'h1,4'h3, 4'h1,4'h3,4'hF,4'hF, 0,0,0,0);
    tbl[5]  = v(4'h5,4'h0,4'h1,4'h3, 4'hF,4'h3,4'hF,4'h1, 0,0,0,1);
    tbl[6]  = v(4'h6,4'h1,4'h1,4'h3, 4'h1,4'h3,4'h3,4'hF, 0,0,1,0);
    tbl[7]  = v(4'h7,4'h2,4'h1,4'h3, 4'hF,4'hF,4'hF,4'hF, 0,0,0,0);
    tbl[8]  = v(4'h8,4'h0,4'h1,4'h3, 4'hF,4'h4,4'h4,4'hF, 0,0,1,0);
    tbl[9]  = v(4'h9,4'h0,4'h1,4'h3, 4'h4,4'h4,4'h4,4'hF, 0,0,1,0);
    tbl[10] = v(4'hA,4'h0,4'h1,4'h3, 4'h1,4'h4,4'h4,4'hF, 0,0,1,0);
    tbl[11] = v(4'hB,4'h0,4'h1,4'h3, 4'h4,4'h4,4'h4,4'h1, 0,0,1,1);
    tbl[12] = v(4'hC,4'h0,4'h1,4'h3, 4'hF,4'hF,4'hF,4'hF, 0,1,0,0);

    do_reset;
    @(negedge clk);
    chk("rst_ex_valid", ex_valid, 0);
    chk("rst_ex_dst_e", ex_dst_e, 4'hF);
    chk("rst_ex_dst_m", ex_dst_m, 4'hF);
    chk("rst_ex_icode", ex_icode, 0);
    chk("rst_ex_cmov", ex_cmov, 0);
    chk("rst_ex_invalid", ex_invalid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_in_ready", in_ready, 1);
    tick;

    for (int i = 0; i < 13; i++) begin
      set_in(tbl[i]);
      @(negedge clk);
      chk($sformatf("tbl%0d_src_a", i), rf_src_a, tbl[i].sa);
      chk($sformatf("tbl%0d_src_b", i), rf_src_b, tbl[i].sb);
      chk($sformatf("tbl%0d_ready", i), in_ready, 1);
      tick;
      in_valid = 1'b0;
      wb(tbl[i].de, tbl[i].dm, 64'h1000 + i, 64'h2000 + i,
         1'b1, tbl[i].cm, tbl[i].we_e, tbl[i].we_m,
         $sformatf("tbl%0d_wb", i));
    end

    // RAW stall on r2, released one cycle after its writeback
    do_reset;
    issue(v(4'h3,4'h0,4'hF,4'h2, 4'hF,4'hF,4'h2,4'hF,0,0,1,0), "t1_irmov");
    set_in(v(4'h6,4'h0,4'h2,4'h3, 4'h2,4'h3,4'h3,4'hF,0,0,1,0));
    @(negedge clk);
    chk("t1_raw_stall0", in_ready, 0);
    tick;
    @(negedge clk);
    chk("t1_raw_stall1", in_ready, 0);
    tick;
    wb_drive(4'h2, 4'hF, 64'h10, 64'h0, 1'b1, 1'b0);
    @(negedge clk);
    chk("t1_wb_we_e", rf_we_e, 1);
    chk("t1_wb_dst_e", rf_dst_e, 4'h2);
    chk("t1_wb_val_e", rf_val_e, 64'h10);
    chk("t1_busy_in_wb", in_ready, 0);
    tick;
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t1_release", in_ready, 1);
    tick;
    in_valid = 1'b0;
    wb(4'h3, 4'hF, 64'h20, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, "t1_wb_add");

    // pushq then popq stalling on %rsp
    set_in(v(4'hA,4'h0,4'h1,4'hF, 4'h1,4'h4,4'h4,4'hF,0,0,1,0));
    @(negedge clk);
    chk("t2_push_src_a", rf_src_a, 4'h1);
    chk("t2_push_src_b", rf_src_b, 4'h4);
    chk("t2_push_ready", in_ready, 1);
    tick;
    set_in(v(4'hB,4'h0,4'h3,4'hF, 4'h4,4'h4,4'h4,4'h3,0,0,1,1));
    @(negedge clk);
    chk("t2_pop_stall", in_ready, 0);
    tick;
    wb(4'h4, 4'hF, 64'hF8, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, "t2_wb_push");
    @(negedge clk);
    chk("t2_pop_release", in_ready, 1);
    tick;
    in_valid = 1'b0;
    wb(4'h4, 4'h3, 64'h100, 64'hAB, 1'b1, 1'b0, 1'b1, 1'b1, "t2_wb_pop");

    // popq %rsp: one tag, M wins
    issue(v(4'hB,4'h0,4'h4,4'hF, 4'h4,4'h4,4'h4,4'h4,0,0,0,1), "t3_pop");
    wb(4'h4, 4'h4, 64'h100, 64'h55, 1'b1, 1'b0, 1'b0, 1'b1, "t3_wb");
    set_in(v(4'hA,4'h0,4'h1,4'hF, 4'h1,4'h4,4'h4,4'hF,0,0,1,0));
    @(negedge clk);
    chk("t3_rsp_free", in_ready, 1);
    tick;
    in_valid = 1'b0;
    wb(4'h4, 4'hF, 64'h30, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, "t3_wb_push");

    // cmovle not taken still frees r5
    issue(v(4'h2,4'h1,4'h1,4'h5, 4'h1,4'hF,4'h5,4'hF,1,0,0,0), "t4_cmov");
    set_in(v(4'h3,4'h0,4'hF,4'h5, 4'hF,4'hF,4'h5,4'hF,0,0,1,0));
    @(negedge clk);
    chk("t4_stall", in_ready, 0);
    tick;
    wb(4'h5, 4'hF, 64'h77, 64'h0, 1'b0, 1'b1, 1'b0, 1'b0, "t4_wb_cmov");
    @(negedge clk);
    chk("t4_release", in_ready, 1);
    tick;
    in_valid = 1'b0;
    wb(4'h5, 4'hF, 64'h40, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, "t4_wb_irmov");

    // in-flight limit
    do_reset;
    for (int r = 8; r < 12; r++)
      issue(v(4'h3,4'h0,4'hF,4'(r), 4'hF,4'hF,4'(r),4'hF,0,0,1,0),
            $sformatf("t5_irmov%0d", r));
    set_in(v(4'h3,4'h0,4'hF,4'hC, 4'hF,4'hF,4'hC,4'hF,0,0,1,0));
    @(negedge clk);
    chk("t5_cap_stall", in_ready, 0);
    tick;
    wb(4'h8, 4'hF, 64'h8, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, "t5_wb8");
    @(negedge clk);
    chk("t5_cap_release", in_ready, 1);
    tick;
    in_valid = 1'b0;
    for (int r = 9; r < 13; r++)
      wb(4'(r), 4'hF, 64'(r), 64'h0, 1'b1, 1'b0, 1'b1, 1'b0,
         $sformatf("t5_wb%0d", r));

    // halt with two in flight, then reset mid-stream
    do_reset;
    issue(v(4'h3,4'h0,4'hF,4'h2, 4'hF,4'hF,4'h2,4'hF,0,0,1,0), "t6_irmov");
    issue(v(4'h0,4'h0,4'hF,4'hF, 4'hF,4'hF,4'hF,4'hF,0,0,0,0), "t6_halt");
    set_in(v(4'h1,4'h0,4'hF,4'hF, 4'hF,4'hF,4'hF,4'hF,0,0,0,0));
    @(negedge clk);
    chk("t6_halt_block", in_ready, 0);
    chk("t6_not_halted0", halted, 0);
    tick;
    wb(4'h2, 4'hF, 64'h2, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, "t6_wb_irmov");
    @(negedge clk);
    chk("t6_not_halted1", halted, 0);
    tick;
    wb(4'hF, 4'hF, 64'h0, 64'h0, 1'b1, 1'b0, 1'b0, 1'b0, "t6_wb_halt");
    @(negedge clk);
    chk("t6_halted", halted, 1);
    chk("t6_still_blocked", in_ready, 0);
    tick;
    in_valid = 1'b0;

    do_reset;
    chk("t6_reset_unhalt", halted, 0);
    ex_ready = 1'b0;
    issue(v(4'h3,4'h0,4'hF,4'h6, 4'hF,4'hF,4'h6,4'hF,0,0,1,0), "t6_irmov6");
    set_in(v(4'h3,4'h0,4'hF,4'h7, 4'hF,4'hF,4'h7,4'hF,0,0,1,0));
    @(negedge clk);
    chk("t6_ex_held_valid", ex_valid, 1);
    chk("t6_backpressure", in_ready, 0);
    tick;
    @(negedge clk);
    chk("t6_ex_held_dst", ex_dst_e, 4'h6);
    tick;
    reset    = 1'b1;
    in_valid = 1'b0;
    q.delete();
    tick;
    reset    = 1'b0;
    ex_ready = 1'b1;
    @(negedge clk);
    chk("t6_mid_rst_ex_valid", ex_valid, 0);
    chk("t6_mid_rst_dst_e", ex_dst_e, 4'hF);
    tick;
    set_in(v(4'h6,4'h0,4'h6,4'h6, 4'h6,4'h6,4'h6,4'hF,0,0,1,0));
    @(negedge clk);
    chk("t6_pending_cleared", in_ready, 1);
    tick;
    in_valid = 1'b0;
    wb(4'h6, 4'hF, 64'h66, 64'h0, 1'b1, 1'b0, 1'b1, 1'b0, "t6_wb_add");
    tick;

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
